// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared types for the CPU clock-enable controller: FSM state encoding and
// board mode-switch values.
package cpu_clock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_STOP = 3'd0,
        ST_RUN  = 3'd1,
        ST_DBG  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_e;

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_DBG  = 2'b10;
    localparam logic [1:0] MODE_STEP = 2'b11;

    function automatic state_e mode_to_state(input logic [1:0] mode);
        state_e st;
        case (mode)
            MODE_RUN:  st = ST_RUN;
            MODE_DBG:  st = ST_DBG;
            MODE_STEP: st = ST_STEP;
            default:   st = ST_STOP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/cpu_clock_ctrl_key_debounce.sv
// Level debouncer for the step push button: the output follows the input only
// after DEBOUNCE_CYCLES consecutive cycles of disagreement. Output idles high.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic key_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_q, key_d;

    always_comb begin
        cnt_d = cnt_q;
        key_d = key_q;
        if (key_i == key_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            key_d = key_i;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            key_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            key_q <= key_d;
        end
    end

    assign key_o = key_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Turns divider taps / step button into single-cycle CPU clock enables on CLOCK_50.
// Optional active-cycle counter enabled by defining CPU_CLOCK_CTRL_CYCLE_COUNT_EN.
module cpu_clock_ctrl
    import cpu_clock_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             divclock,
    input  logic             depclock,
    input  logic [1:0]       mode_sel,
    input  logic             step_key,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic [2:0]       state_o,
    output logic [3:0]       LEDR,
    output logic [CNT_W-1:0] cycle_count
);

    logic [1:0] mode_s1_q, mode_s2_q;
    logic       key_s1_q, key_s2_q;
    logic       div_q, dep_q;
    logic       key_db;
    logic       key_db_q;
    state_e     state_q, state_d;
    logic       cpu_en_q, cpu_en_d;
    logic [3:0] led_q, led_d;
    logic       div_rise, dep_rise, press, en_src;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            mode_s1_q <= '0;
            mode_s2_q <= '0;
            key_s1_q  <= 1'b0;
            key_s2_q  <= 1'b0;
            div_q     <= 1'b0;
            dep_q     <= 1'b0;
            key_db_q  <= 1'b1;
        end else begin
            mode_s1_q <= mode_sel;
            mode_s2_q <= mode_s1_q;
            key_s1_q  <= step_key;
            key_s2_q  <= key_s1_q;
            div_q     <= divclock;
            dep_q     <= depclock;
            key_db_q  <= key_db;
        end
    end

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk_i  (CLOCK_50),
        .rst_ni (reset),
        .key_i  (key_s2_q),
        .key_o  (key_db)
    );

    assign div_rise = divclock & ~div_q;
    assign dep_rise = depclock & ~dep_q;
    assign press    = ~key_db & key_db_q;

    always_comb begin
        state_d = state_q;
        if (halt_req) begin
            state_d = ST_HALT;
        end else if (state_q == ST_HALT) begin
            if (mode_s2_q == MODE_STOP) state_d = ST_STOP;
        end else begin
            state_d = mode_to_state(mode_s2_q);
        end
    end

    // Enable sources are gated by the current state, so edges that coincide
    // with a mode change are judged against the old state.
    always_comb begin
        en_src = 1'b0;
        case (state_q)
            ST_RUN:  en_src = div_rise;
            ST_DBG:  en_src = dep_rise;
            ST_STEP: en_src = press;
            default: en_src = 1'b0;
        endcase
        cpu_en_d = en_src & ~halt_req;
        led_d    = cpu_en_d ? led_q + 4'd1 : led_q;
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_STOP;
            cpu_en_q <= 1'b0;
            led_q    <= '0;
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
            led_q    <= led_d;
        end
    end

    assign cpu_en  = cpu_en_q;
    assign state_o = state_q;
    assign LEDR    = led_q;

`ifdef CPU_CLOCK_CTRL_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if ((state_q == ST_RUN || state_q == ST_DBG || state_q == ST_STEP) && cyc_q != '1)
            cyc_d = cyc_q + CNT_W'(1);
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed self-checking bench for cpu_clock_ctrl; the divider is modelled by a
// free-running counter (divclock = cnt[5], depclock = cnt[15]) that can be preloaded.
module tb_cpu_clock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] mode_sel = 2'b01;
    logic       step_key = 1'b1;
    logic       halt_req = 1'b0;
    logic       cpu_en;
    logic [2:0] state_o;
    logic [3:0] LEDR;
    logic [3:0] cycle_count;
    logic       divclock, depclock;

    logic [31:0] div_cnt;
    logic        cnt_load = 1'b0;
    logic [31:0] cnt_load_val = '0;

    int unsigned tests = 0;
    int unsigned fails = 0;

    int unsigned neg_cyc = 0;
    int unsigned pulses = 0;
    int unsigned wide_cnt = 0;
    logic        prev_en = 1'b0;
    int unsigned pulse_t[$];

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        div_cnt <= '0;
        else if (cnt_load) div_cnt <= cnt_load_val;
        else               div_cnt <= div_cnt + 32'd1;
    end

    assign divclock = div_cnt[5];
    assign depclock = div_cnt[15];

    cpu_clock_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(4)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (rst_n),
        .divclock    (divclock),
        .depclock    (depclock),
        .mode_sel    (mode_sel),
        .step_key    (step_key),
        .halt_req    (halt_req),
        .cpu_en      (cpu_en),
        .state_o     (state_o),
        .LEDR        (LEDR),
        .cycle_count (cycle_count)
    );

    // Pulse monitor: counts cpu_en pulses and flags any enable lasting >1 cycle.
    always @(negedge clk) begin
        neg_cyc = neg_cyc + 1;
        if (cpu_en === 1'b1) begin
            pulses = pulses + 1;
            pulse_t.push_back(neg_cyc);
            if (prev_en === 1'b1) wide_cnt = wide_cnt + 1;
        end
        prev_en = cpu_en;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_cnt(input logic [31:0] v);
        cnt_load_val = v;
        cnt_load     = 1'b1;
        tick(1);
        cnt_load     = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int unsigned p0;
    int unsigned gap_bad;
    logic        found;
    logic [3:0]  cc_exp_mid, cc_exp_sat;

    initial begin
`ifdef CPU_CLOCK_CTRL_CYCLE_COUNT_EN
        cc_exp_mid = 4'd7;
        cc_exp_sat = 4'd15;
`else
        cc_exp_mid = 4'd0;
        cc_exp_sat = 4'd0;
`endif
        #1 rst_n = 1'b0;
        tick(3);
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_state", {29'd0, state_o}, 32'd0);
        chk("rst_ledr", {28'd0, LEDR}, 32'd0);
        chk("rst_cycle_count", {28'd0, cycle_count}, 32'd0);

        // Run mode: first rise at cnt=32, pulses every 64 cycles
        rst_n = 1'b1;
        pulse_t.delete();
        p0 = pulses;
        tick(640);
        chk("run_pulses", pulses - p0, 32'd10);
        chk("run_ledr", {28'd0, LEDR}, 32'd10);
        chk("run_state", {29'd0, state_o}, 32'd1);
        gap_bad = 0;
        for (int i = 1; i < pulse_t.size(); i++)
            if (pulse_t[i] - pulse_t[i-1] != 64) gap_bad++;
        chk("run_gap64", gap_bad, 32'd0);

        // Debug mode: divider fast-forwarded to just before each depclock rise
        mode_sel = 2'b10;
        p0 = pulses;
        load_cnt(32'd32704);
        tick(99);
        chk("dbg_pulse1", pulses - p0, 32'd1);
        load_cnt(32'd98268);
        tick(99);
        chk("dbg_pulse2", pulses - p0, 32'd2);
        chk("dbg_ledr", {28'd0, LEDR}, 32'd12);
        mode_sel = 2'b00;
        tick(4);
        chk("stop_state", {29'd0, state_o}, 32'd0);
        p0 = pulses;
        load_cnt(32'd163824);
        tick(63);
        chk("stop_no_pulse", pulses - p0, 32'd0);
        chk("stop_state_hold", {29'd0, state_o}, 32'd0);

        // Step mode with a bouncy key
        rst_n = 1'b0;
        mode_sel = 2'b11;
        step_key = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("step_state", {29'd0, state_o}, 32'd3);
        p0 = pulses;
        step_key = 1'b0; tick(1);
        step_key = 1'b1; tick(1);
        step_key = 1'b0; tick(1);
        tick(20);
        chk("step_press1", pulses - p0, 32'd1);
        chk("step_ledr1", {28'd0, LEDR}, 32'd1);
        step_key = 1'b1;
        tick(12);
        chk("step_release", pulses - p0, 32'd1);
        step_key = 1'b0;
        tick(12);
        chk("step_press2", pulses - p0, 32'd2);
        chk("step_ledr2", {28'd0, LEDR}, 32'd2);
        step_key = 1'b1;
        tick(12);

        // Press while stopped must be dropped, not delivered on entering step
        mode_sel = 2'b00;
        tick(4);
        chk("discard_stop_state", {29'd0, state_o}, 32'd0);
        p0 = pulses;
        step_key = 1'b0;
        tick(12);
        mode_sel = 2'b11;
        tick(8);
        chk("discard_step_state", {29'd0, state_o}, 32'd3);
        chk("discard_no_pulse", pulses - p0, 32'd0);
        chk("discard_ledr", {28'd0, LEDR}, 32'd2);
        step_key = 1'b1;
        tick(12);

        // Halt coincident with a divclock rise
        mode_sel = 2'b01;
        tick(4);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (div_cnt[5:0] == 6'd32) found = 1'b1;
            else tick(1);
        end
        chk("halt_found_rise", {31'd0, found}, 32'd1);
        halt_req = 1'b1;
        p0 = pulses;
        tick(1);
        halt_req = 1'b0;
        chk("halt_state", {29'd0, state_o}, 32'd4);
        tick(100);
        chk("halt_no_pulse", pulses - p0, 32'd0);
        chk("halt_stays", {29'd0, state_o}, 32'd4);
        mode_sel = 2'b00;
        tick(4);
        chk("halt_exit_stop", {29'd0, state_o}, 32'd0);
        mode_sel = 2'b01;
        tick(4);
        p0 = pulses;
        tick(128);
        chk("halt_resume", pulses - p0, 32'd2);

        // Asynchronous reset during the enable-high cycle
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1);
            if (cpu_en === 1'b1) found = 1'b1;
        end
        chk("rst_pulse_found", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        #2;
        chk("rstmid_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rstmid_state", {29'd0, state_o}, 32'd0);
        chk("rstmid_ledr", {28'd0, LEDR}, 32'd0);

        // Active-cycle counter (run entered 3 cycles after release)
        tick(1);
        rst_n = 1'b1;
        tick(10);
        chk("cc_count", {28'd0, cycle_count}, {28'd0, cc_exp_mid});
        tick(20);
        chk("cc_saturate", {28'd0, cycle_count}, {28'd0, cc_exp_sat});
        chk("cc_state", {29'd0, state_o}, 32'd1);

        chk("pulse_width", wide_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
